// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: polarity fix, two-flop synchroniser,
// tick-paced debounce, press/release strobes and per-channel auto-repeat.
module button_conditioner #(
  parameter int N_CH           = 4,
  parameter int CNT_W          = 20,
  parameter int DEBOUNCE_TICKS = 50000,
  parameter int REPEAT_DELAY   = 500000,
  parameter int REPEAT_RATE    = 100000,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [N_CH-1:0] repeat_en,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] pressed,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_pressed
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RATE  = 2'd2
  } rep_state_t;

  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_pressed_nxt;
  logic            r_any_pressed;

  assign w_level = ACTIVE_LOW ? ~btn_raw : btn_raw;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic             r_s1;
    logic             r_s2;
    logic             r_pressed;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] w_db_cnt_nxt;
    logic             w_accept;
    logic             r_press_pulse;
    logic             r_release_pulse;
    rep_state_t       r_state;
    rep_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [CNT_W-1:0] w_rep_cnt_nxt;
    logic             w_rep_fire;
    logic             r_repeat_pulse;

    // Two-flop synchroniser on the polarity-corrected level
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= w_level[g];
        r_s2 <= r_s1;
      end
    end

    // Debounce: the terminal compare wins over increment so the counter never wraps
    always_comb begin
      w_db_cnt_nxt = r_db_cnt;
      w_accept     = 1'b0;
      if (r_s2 == r_pressed) begin
        w_db_cnt_nxt = '0;
      end else if (tick) begin
        if (r_db_cnt == DB_LAST) begin
          w_accept     = 1'b1;
          w_db_cnt_nxt = '0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
      end else begin
        w_db_cnt_nxt = r_db_cnt;
      end
    end

    assign w_pressed_nxt[g] = w_accept ? r_s2 : r_pressed;

    // Debounced level and edge strobes, issued on the edge the level changes
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_db_cnt        <= '0;
        r_pressed       <= 1'b0;
        r_press_pulse   <= 1'b0;
        r_release_pulse <= 1'b0;
      end else begin
        r_db_cnt        <= w_db_cnt_nxt;
        r_pressed       <= w_pressed_nxt[g];
        r_press_pulse   <= w_accept & r_s2;
        r_release_pulse <= w_accept & ~r_s2;
      end
    end

    // Repeat FSM state register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= ST_IDLE;
        r_rep_cnt <= '0;
      end else begin
        r_state   <= w_state_nxt;
        r_rep_cnt <= w_rep_cnt_nxt;
      end
    end

    // Repeat FSM next state; uses the upcoming level so DELAY starts with the press strobe
    always_comb begin
      w_state_nxt   = r_state;
      w_rep_cnt_nxt = r_rep_cnt;
      if (!w_pressed_nxt[g] || !repeat_en[g]) begin
        w_state_nxt   = ST_IDLE;
        w_rep_cnt_nxt = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_state_nxt   = ST_DELAY;
            w_rep_cnt_nxt = '0;
          end
          ST_DELAY: begin
            if (tick && (r_rep_cnt == RD_LAST)) begin
              w_state_nxt   = ST_RATE;
              w_rep_cnt_nxt = '0;
            end else if (tick) begin
              w_rep_cnt_nxt = r_rep_cnt + 1'b1;
            end else begin
              w_rep_cnt_nxt = r_rep_cnt;
            end
          end
          ST_RATE: begin
            if (tick && (r_rep_cnt == RR_LAST)) begin
              w_rep_cnt_nxt = '0;
            end else if (tick) begin
              w_rep_cnt_nxt = r_rep_cnt + 1'b1;
            end else begin
              w_rep_cnt_nxt = r_rep_cnt;
            end
          end
          default: begin
            w_state_nxt   = ST_IDLE;
            w_rep_cnt_nxt = '0;
          end
        endcase
      end
    end

    // Repeat FSM output decode
    always_comb begin
      w_rep_fire = 1'b0;
      if (w_pressed_nxt[g] && repeat_en[g] && tick) begin
        case (r_state)
          ST_DELAY: w_rep_fire = (r_rep_cnt == RD_LAST);
          ST_RATE:  w_rep_fire = (r_rep_cnt == RR_LAST);
          default:  w_rep_fire = 1'b0;
        endcase
      end else begin
        w_rep_fire = 1'b0;
      end
    end

    // Registered repeat strobe
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_repeat_pulse <= 1'b0;
      end else begin
        r_repeat_pulse <= w_rep_fire;
      end
    end

    assign pressed[g]       = r_pressed;
    assign press_pulse[g]   = r_press_pulse;
    assign release_pulse[g] = r_release_pulse;
    assign repeat_pulse[g]  = r_repeat_pulse;
  end

  // Aggregate level, aligned with the per-channel pressed outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_any_pressed <= 1'b0;
    end else begin
      r_any_pressed <= |w_pressed_nxt;
    end
  end

  assign any_pressed = r_any_pressed;

endmodule
